// File: rtl/comb_a_seq.sv
// Sequencer for the comb_A datapath: latches an operand pair and walks the
// enabled control codes in ascending order, with one settle and one sample cycle per code.
module comb_a_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       code_mask,
  input  logic [WIDTH-1:0] opA_in,
  input  logic [WIDTH-1:0] opB_in,
  input  logic             zero1,
  input  logic             zero2,
  output logic             c1,
  output logic             c2,
  output logic             c3,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [7:0]       z1_vec,
  output logic [7:0]       z2_vec
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_DRIVE  = 2'b01;
  localparam logic [1:0] ST_SAMPLE = 2'b10;
  localparam logic [1:0] ST_DONE   = 2'b11;

  logic [1:0]       state_reg, state_next;
  logic [2:0]       code_reg, code_next;
  logic [7:0]       mask_reg, mask_next;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [7:0]       z1_reg, z1_next;
  logic [7:0]       z2_reg, z2_next;
  logic [7:0]       above_mask;
  logic [2:0]       start_code;
  logic [2:0]       next_code;
  logic             active;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest = 3'(i);
    end
  endfunction

  // Enabled codes strictly above the current one; empty means the sweep is finished.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_above
      assign above_mask[gi] = mask_reg[gi] && (code_reg < 3'(gi));
    end
  endgenerate

  assign start_code = lowest(code_mask);
  assign next_code  = lowest(above_mask);

  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    mask_next  = mask_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    z1_next    = z1_reg;
    z2_next    = z2_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          opa_next   = opA_in;
          opb_next   = opB_in;
          mask_next  = code_mask;
          z1_next    = 8'h00;
          z2_next    = 8'h00;
          code_next  = start_code;
          state_next = (code_mask == 8'h00) ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        z1_next[code_reg] = zero1;
        z2_next[code_reg] = zero2;
        if (above_mask != 8'h00) begin
          code_next  = next_code;
          state_next = ST_DRIVE;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      code_reg  <= 3'd0;
      mask_reg  <= 8'h00;
      opa_reg   <= '0;
      opb_reg   <= '0;
      z1_reg    <= 8'h00;
      z2_reg    <= 8'h00;
    end else begin
      state_reg <= state_next;
      code_reg  <= code_next;
      mask_reg  <= mask_next;
      opa_reg   <= opa_next;
      opb_reg   <= opb_next;
      z1_reg    <= z1_next;
      z2_reg    <= z2_next;
    end
  end

  // Control code reaches comb_A only while a code is being settled or sampled.
  assign active       = (state_reg == ST_DRIVE) || (state_reg == ST_SAMPLE);
  assign {c3, c2, c1} = active ? code_reg : 3'b000;
  assign busy         = active;
  assign done         = (state_reg == ST_DONE);
  assign opA          = opa_reg;
  assign opB          = opb_reg;
  assign z1_vec       = z1_reg;
  assign z2_vec       = z2_reg;

endmodule

// File: doc/comb_a_seq.md
# comb_a_seq

Sequencer for the `comb_A` control/compare datapath. On a `start` request it latches one 16-bit operand pair and drives it onto `comb_A`. It then steps the 3-bit control code `{c3,c2,c1}` through every code enabled in a mask, allowing one settle cycle and one sample cycle per code. It collects `zero1`/`zero2` into two 8-bit result vectors. It sits between the top-level control logic and a combinational `comb_A` instance, and is the only driver of that instance's inputs.

## Interface
Parameters:
- `WIDTH`, 16, operand width driven to `comb_A`.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, and the reset is synchronous and active-high.
- `start`  in  1  request pulse/level; accepted only in IDLE.
- `code_mask`  in  8  bit k=1 enables control code k; sampled with `start`.
- `opA_in`, `opB_in`  in  WIDTH  operands; sampled with `start`.
- `zero1`, `zero2`  in  1  flags returned by `comb_A`.
- `c1`, `c2`, `c3`  out  1  control code to `comb_A`; `c1` is the LSB of the code.
- `opA`, `opB`  out  WIDTH  latched operands to `comb_A`.
- `busy`  out  1  high in DRIVE and SAMPLE.
- `done`  out  1  one-cycle pulse in DONE.
- `z1_vec`, `z2_vec`  out  8  bit k = sampled `zero1`/`zero2` for code k.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE with `start`=1:
  - Latch `opA_in`/`opB_in` into `opA`/`opB` and latch `code_mask`.
  - Clear `z1_vec`/`z2_vec` to 0.
  - Load `code` with the lowest enabled index.
  - If mask=0, go to DONE; otherwise go to DRIVE.
- DRIVE: `{c3,c2,c1}` = `code`. This is the settle cycle; flags are ignored. Next state is always SAMPLE.
- SAMPLE:
  - `{c3,c2,c1}` still = `code`.
  - At the edge ending SAMPLE, write `z1_vec[code]`←`zero1` and `z2_vec[code]`←`zero2`.
  - Then load the next higher enabled index and go to DRIVE, or go to DONE if none remain.
- DONE: `done`=1 and `{c3,c2,c1}`=0; next state is IDLE.
- Codes are visited in strictly ascending order, with no wrap-around past 7. Disabled codes are never driven and their result bits stay 0.
- `opA`/`opB` are constant from acceptance until the next accepted `start`; IDLE keeps the last operands.
- `{c3,c2,c1}`=000 in IDLE and DONE.
- `z1_vec`/`z2_vec` hold their values from DONE until the next accepted `start`.
- `start` in any state other than IDLE is ignored, with no queuing. A `start` held high through DONE is accepted in the following IDLE cycle.
- `start` in the same cycle as `reset`: reset wins.

## Timing
- Reset (synchronous):
  - State → IDLE.
  - `c1`=`c2`=`c3`=0, `opA`=`opB`=0, `busy`=0, `done`=0, `z1_vec`=`z2_vec`=0.
  - The internal mask and `code` are cleared.
- `start` accepted at edge T; let n = number of enabled codes:
  - n≥1: `busy` rises after T and stays high 2n cycles. `done` is high in cycle T+2n+1, then IDLE.
  - n=0: `done` is high in the cycle immediately after T; `busy` is never asserted.
- Per code, `{c3,c2,c1}` is stable for exactly 2 cycles (DRIVE+SAMPLE).
- `zero1`/`zero2` are sampled once per code, only at the edge ending SAMPLE, one full cycle after the code was applied.
- Minimum start-to-start spacing: 2n+2 cycles.
- Reset mid-sequence (DRIVE or SAMPLE):
  - Next cycle is IDLE with all outputs at reset values.
  - Partial results are discarded, and no `done` is produced.

## Test plan
- Reset then idle:
  - Stimulus: `reset`=1 for 2 cycles, then idle 5 cycles.
  - Required: all outputs 0, `busy`=`done`=0 throughout.
- Full sweep:
  - Stimulus: `code_mask`=8'hFF, `opA_in`=16'h0001, `opB_in`=16'h0000. Bench `comb_A` model drives `zero1`=(code==3'b101) and `zero2`=(opA==opB).
  - Required: codes 0..7 each held 2 cycles; `done` 17 cycles after the accepting edge; `z1_vec`=8'h20, `z2_vec`=8'h00.
- Sparse mask:
  - Stimulus: `code_mask`=8'b1000_0100, `opA_in`=`opB_in`=16'h1234.
  - Required: only codes 2 then 7 driven; `done` 5 cycles after acceptance; `z2_vec`=8'h84.
- Empty mask:
  - Stimulus: `code_mask`=0.
  - Required: `done` on the next cycle, `busy` never high, vectors 0, `{c3,c2,c1}`=000.
- Ignored start and settle discipline:
  - Stimulus: pulse `start` with new operands while `busy`. Model toggles `zero1` during DRIVE only.
  - Required: `opA`/`opB` unchanged; toggles during DRIVE not captured.
- Reset mid-op:
  - Stimulus: assert `reset` in the SAMPLE cycle of code 3 during an 8'hFF sweep.
  - Required: next cycle IDLE, vectors 0, no `done`. A following `start` completes a normal sweep.
